// File: rtl/video_bus_master.sv
// Host-side initiator for the video card's 8-bit parallel CPU bus, with programmable setup/strobe/hold/recovery timing.
// Optional wait-state input enabled by defining VIDEO_BUS_WAIT_EN.
module video_bus_master #(
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 3,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 2,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [2:0]       req_addr,
    input  logic [7:0]       req_wdata,
    output logic             rsp_valid,
    output logic [7:0]       rsp_rdata,
    output logic             ncs,
    output logic             nwr,
    output logic             nrd,
    output logic [2:0]       addr,
    output logic [7:0]       data_out,
    output logic             data_oe,
`ifdef VIDEO_BUS_WAIT_EN
    input  logic             nwait,
`endif
    input  logic [7:0]       data_in
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SETUP   = 3'd1;
    localparam logic [2:0] STROBE  = 3'd2;
    localparam logic [2:0] HOLD    = 3'd3;
    localparam logic [2:0] RECOVER = 3'd4;

    localparam int SETUP_N  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int STROBE_N = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
    localparam int HOLD_N   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;
    localparam int REC_N    = (RECOVERY_CYCLES < 1) ? 1 : RECOVERY_CYCLES;

    // Counter load values: each phase runs while the counter counts down to zero.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_N - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_N - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_N - 1);
    localparam logic [CNT_W-1:0] REC_LD    = CNT_W'(REC_N - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             is_write;
    logic             stretch;
    logic             timeout;

    assign req_ready = (state == IDLE) && !reset;

`ifdef VIDEO_BUS_WAIT_EN
    logic [1:0]  nwait_sync;
    logic [15:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            nwait_sync <= 2'b11;
        end else begin
            nwait_sync <= {nwait_sync[0], nwait};
        end
    end

    // Counts extension cycles spent in the last strobe cycle; saturation is the timeout.
    always_ff @(posedge clk) begin
        if (reset || state != STROBE) begin
            wait_cnt <= '0;
        end else if (cnt == '0 && stretch) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign stretch = !nwait_sync[1] && (wait_cnt != 16'hFFFF);
    assign timeout = !nwait_sync[1] && (wait_cnt == 16'hFFFF);
`else
    assign stretch = 1'b0;
    assign timeout = 1'b0;
`endif

    // NOTE: all state updates below use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            is_write  <= 1'b0;
            ncs       <= 1'b1;
            nwr       <= 1'b1;
            nrd       <= 1'b1;
            addr      <= '0;
            data_out  <= '0;
            data_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        is_write <= req_write;
                        addr     <= req_addr;
                        ncs      <= 1'b0;
                        data_oe  <= req_write;
                        if (req_write) begin
                            data_out <= req_wdata;
                        end
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        nwr   <= !is_write;
                        nrd   <= is_write;
                        cnt   <= STROBE_LD;
                        state <= STROBE;
                    end
                end
                STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!stretch) begin
                        nwr <= 1'b1;
                        nrd <= 1'b1;
                        if (timeout) begin
                            rsp_rdata <= 8'hFF;
                        end else if (!is_write) begin
                            rsp_rdata <= data_in;
                        end
                        cnt   <= HOLD_LD;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        ncs       <= 1'b1;
                        data_oe   <= 1'b0;
                        rsp_valid <= 1'b1;
                        cnt       <= REC_LD;
                        // With no recovery the response cycle doubles as the next IDLE cycle.
                        state     <= (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
                    end
                end
                RECOVER: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/video_bus_master.md
Name: video_bus_master

Overview:
- Host-side initiator for the video card's 8-bit parallel CPU bus: ncs, nwr, nrd, addr[2:0], data[7:0].
- Turns single-beat read/write requests from an internal valid/ready port into correctly sequenced bus cycles, with programmable setup, strobe, hold and recovery timing.
- Used in FPGA host designs and as the bus driver in video-card system benches.
- The tri-state pad is not inside this block: the top level builds the inout from data_out/data_oe.

Parameters:
- SETUP_CYCLES, 2, cycles ncs/addr/data are valid before the strobe falls; values below 1 are treated as 1.
- STROBE_CYCLES, 3, cycles nwr or nrd is held low; values below 1 are treated as 1.
- HOLD_CYCLES, 1, cycles ncs/addr/data are held after the strobe rises; values below 1 are treated as 1.
- RECOVERY_CYCLES, 2, cycles ncs is high before the next request is accepted; 0 is allowed.
- CNT_W, 8, width of the phase counter; every timing parameter must be less than 2^CNT_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  a request is presented.
- req_ready  out  1  high only in IDLE; a request transfers when req_valid and req_ready are both high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  3  register address.
- req_wdata  in  8  write data.
- rsp_valid  out  1  one-cycle pulse when a transaction completes.
- rsp_rdata  out  8  read data; valid while rsp_valid is high; holds its last value otherwise.
- ncs  out  1  chip select, active low.
- nwr  out  1  write strobe, active low.
- nrd  out  1  read strobe, active low.
- addr  out  3  bus address.
- data_out  out  8  bus write data.
- data_oe  out  1  enables the data pad output driver.
- data_in  in  8  bus read data from the pad.

Behaviour:
- Reset values: ncs=1, nwr=1, nrd=1, addr=0, data_out=0, data_oe=0, req_ready=0 during reset and 1 in the cycle after reset, rsp_valid=0, rsp_rdata=0, state=IDLE.
- All bus outputs are registered; no combinational path from request inputs to bus pins.
- States and transitions:
  - IDLE: req_ready=1. On transfer, latch write/addr/wdata, load the counter, go to SETUP.
  - SETUP (SETUP_CYCLES cycles): ncs=0, addr driven. For a write, data_oe=1 and data_out=wdata. nwr=nrd=1.
  - STROBE (STROBE_CYCLES cycles): nwr=0 for a write, nrd=0 for a read.
    - A read samples data_in into rsp_rdata at the clock edge that ends the last STROBE cycle.
  - HOLD (HOLD_CYCLES cycles): both strobes high; ncs, addr and data are held.
  - RECOVER (RECOVERY_CYCLES cycles): ncs=1, data_oe=0; addr keeps its last value.
    - rsp_valid=1 in the first cycle after HOLD, for both reads and writes.
    - If RECOVERY_CYCLES=0, that rsp_valid cycle is the IDLE cycle, and a new request may transfer in it.
- Timing with defaults, counting the transfer edge as edge 0:
  - Cycles 1-2: SETUP.
  - Cycles 3-5: STROBE.
  - Cycle 6: HOLD.
  - Cycles 7-8: RECOVER; rsp_valid=1 in cycle 7.
  - Cycle 9: IDLE, req_ready=1.
- Invariants:
  - A strobe is never low while ncs is high.
  - A strobe never falls in the same cycle ncs falls.
  - nwr and nrd are never low together.
  - data_oe is never 1 during a read transaction.
- Request inputs are ignored outside IDLE.
- Reset mid-transaction: on the next edge all outputs return to their reset values. No rsp_valid is produced for the aborted transaction.

Optional Feature:
- Macro: VIDEO_BUS_WAIT_EN.
- When defined:
  - Adds input nwait (1 bit, active low), synchronised through 2 flops inside the block.
  - In the last STROBE cycle, if synchronised nwait=0, the block stays in STROBE (strobe held low) until nwait=1, then completes normally. The read sample moves to the edge that ends the extended strobe.
  - Adds a 16-bit wait timeout. On expiry the block completes the cycle and pulses rsp_valid with rsp_rdata=8'hFF.
- When undefined: there is no nwait port and the strobe width is exactly STROBE_CYCLES.

Test Plan:
- Write addr=3, wdata=8'hA5, defaults: ncs low for cycles 1-6; nwr low for cycles 3-5 only; data_oe=1 and data_out=A5 for cycles 1-6; rsp_valid in cycle 7 only; req_ready high again in cycle 9.
- Read addr=5 with the bench driving data_in=8'h3C during strobe: nrd low for cycles 3-5, data_oe stays 0, rsp_valid in cycle 7 with rsp_rdata=3C.
- Back-to-back requests with req_valid held high, RECOVERY_CYCLES=0: second SETUP starts in the cycle after IDLE; ncs is high for exactly 1 cycle between transactions.
- Assert reset during STROBE of a write: next cycle ncs=nwr=1, data_oe=0, no rsp_valid; the next request completes normally.
- Change req_addr/req_wdata mid-transaction: bus outputs are unchanged; all invariants hold under randomised parameters 1..4.
- With VIDEO_BUS_WAIT_EN defined, hold nwait=0 for 10 cycles: nrd low for at least 12 cycles and rsp_rdata equals data_in at strobe end. Holding nwait=0 permanently gives rsp_rdata=FF after timeout.
